// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM stage of the 5-stage MIPS-32 pipeline, sitting between EX_MEM and
// MEM_WB. Issues loads and stores over a req/ack data-memory port, aligns
// and extends load data, and stalls the upstream stages while an access is
// outstanding. Produces the bundle that MEM_WB registers.
//
// Ports
//   clock, reset_n      pipeline clock (rising edge), async active-low reset
//   inValid             EX_MEM bundle valid
//   aluResult[31:0]     effective address / ALU result
//   writeData[31:0]     store data (rt)
//   muxInst[4:0]        destination register
//   WB[1:0]             {RegWrite, MemtoReg}
//   memRead, memWrite   load / store (both set is treated as a load)
//   memSize[1:0]        00 byte, 01 half, 10/11 word
//   memUnsigned         zero-extend loads
//   stall               hold EX_MEM and earlier stages
//   dmem_*              data-memory request port (word address, byte enables)
//   readDataOut[31:0]   aligned/extended load data
//   aluResultOut, muxInstOut, WBOut, outValid   registered bundle to MEM_WB
//   misalign, busErr    1-cycle fault pulses
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        inValid,
   input  logic [31:0] aluResult,
   input  logic [31:0] writeData,
   input  logic [4:0]  muxInst,
   input  logic [1:0]  WB,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  memSize,
   input  logic        memUnsigned,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] readDataOut,
   output logic [31:0] aluResultOut,
   output logic [4:0]  muxInstOut,
   output logic [1:0]  WBOut,
   output logic        outValid,
   output logic        misalign,
   output logic        busErr
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] tmo_count;

   // Bundle captured when an access is launched, replayed on completion
   logic [31:0] cap_alu;
   logic [4:0]  cap_inst;
   logic [1:0]  cap_wb;
   logic        cap_load;
   logic [1:0]  cap_size;
   logic        cap_unsigned;

   logic        mem_op;
   logic        is_store;
   logic        misaligned_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic [31:0] rdata_shift;
   logic [31:0] load_data;

   assign stall    = (state == BUSY);
   assign mem_op   = memRead | memWrite;
   assign is_store = memWrite & ~memRead;

   // Alignment check, byte enables and lane-replicated store data for the
   // incoming instruction; size 11 behaves exactly like a word.
   always_comb begin
      misaligned_in = 1'b0;
      be_in         = 4'b1111;
      wdata_in      = writeData;
      case (memSize)
         2'b00: begin
            be_in    = 4'b0001 << aluResult[1:0];
            wdata_in = {4{writeData[7:0]}};
         end
         2'b01: begin
            misaligned_in = aluResult[0];
            be_in         = 4'b0011 << {aluResult[1], 1'b0};
            wdata_in      = {2{writeData[15:0]}};
         end
         default: begin
            misaligned_in = |aluResult[1:0];
         end
      endcase
   end

   // Little-endian lane select: shifting by the byte offset brings the
   // addressed byte/half down to bit 0 (halves are aligned, so a[0]=0).
   always_comb begin
      rdata_shift = dmem_rdata >> {cap_alu[1:0], 3'b000};
      load_data   = dmem_rdata;
      case (cap_size)
         2'b00:   load_data = cap_unsigned ? {24'h0, rdata_shift[7:0]}
                                           : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         2'b01:   load_data = cap_unsigned ? {16'h0, rdata_shift[15:0]}
                                           : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         default: load_data = dmem_rdata;
      endcase
   end

   // Main sequencer. IDLE either passes the bundle straight through, drops a
   // misaligned access, or launches a memory access. BUSY waits for the ack
   // or gives up after TIMEOUT cycles; the request and its address/enables
   // stay registered until the cycle after the ack.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         tmo_count    <= '0;
         cap_alu      <= '0;
         cap_inst     <= '0;
         cap_wb       <= '0;
         cap_load     <= 1'b0;
         cap_size     <= '0;
         cap_unsigned <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= '0;
         dmem_wdata   <= '0;
         readDataOut  <= '0;
         aluResultOut <= '0;
         muxInstOut   <= '0;
         WBOut        <= '0;
         outValid     <= 1'b0;
         misalign     <= 1'b0;
         busErr       <= 1'b0;
      end else begin
         misalign <= 1'b0;
         busErr   <= 1'b0;
         case (state)
            IDLE: begin
               dmem_req <= 1'b0;
               if (!inValid) begin
                  outValid <= 1'b0;
                  WBOut    <= 2'b00;
               end else if (!mem_op) begin
                  outValid     <= 1'b1;
                  aluResultOut <= aluResult;
                  muxInstOut   <= muxInst;
                  WBOut        <= WB;
                  readDataOut  <= '0;
               end else if (misaligned_in) begin
                  outValid     <= 1'b1;
                  aluResultOut <= aluResult;
                  muxInstOut   <= muxInst;
                  WBOut        <= 2'b00;
                  readDataOut  <= '0;
                  misalign     <= 1'b1;
               end else begin
                  outValid     <= 1'b0;
                  WBOut        <= 2'b00;
                  state        <= BUSY;
                  tmo_count    <= '0;
                  cap_alu      <= aluResult;
                  cap_inst     <= muxInst;
                  cap_wb       <= WB;
                  cap_load     <= memRead;
                  cap_size     <= memSize;
                  cap_unsigned <= memUnsigned;
                  dmem_req     <= 1'b1;
                  dmem_we      <= is_store;
                  dmem_addr    <= {aluResult[31:2], 2'b00};
                  dmem_be      <= be_in;
                  dmem_wdata   <= wdata_in;
               end
            end
            default: begin
               if (dmem_ack) begin
                  dmem_req     <= 1'b0;
                  state        <= IDLE;
                  outValid     <= 1'b1;
                  aluResultOut <= cap_alu;
                  muxInstOut   <= cap_inst;
                  WBOut        <= cap_wb;
                  readDataOut  <= cap_load ? load_data : 32'h0;
               end else if (tmo_count == TMO_LAST) begin
                  dmem_req     <= 1'b0;
                  state        <= IDLE;
                  outValid     <= 1'b1;
                  aluResultOut <= cap_alu;
                  muxInstOut   <= cap_inst;
                  WBOut        <= 2'b00;
                  readDataOut  <= '0;
                  busErr       <= 1'b1;
               end else begin
                  outValid  <= 1'b0;
                  WBOut     <= 2'b00;
                  tmo_count <= tmo_count + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed testbench for the MEM stage: ALU pass-through, byte/half/word
// loads with sign/zero extension, stores with byte enables and lane
// replication, misaligned drop, access timeout with a late ack, and reset
// asserted in the middle of an access.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clock;
   logic        reset_n;
   logic        inValid;
   logic [31:0] aluResult;
   logic [31:0] writeData;
   logic [4:0]  muxInst;
   logic [1:0]  WB;
   logic        memRead;
   logic        memWrite;
   logic [1:0]  memSize;
   logic        memUnsigned;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [31:0] readDataOut;
   logic [31:0] aluResultOut;
   logic [4:0]  muxInstOut;
   logic [1:0]  WBOut;
   logic        outValid;
   logic        misalign;
   logic        busErr;

   int numCompared;
   int numMismatched;

   int          stallCycles;
   int          reqCycles;
   logic [31:0] ackAddr;
   logic [3:0]  ackBe;
   logic [31:0] ackWdata;
   logic        ackWe;

   mem_access_unit #(.TIMEOUT(16)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .inValid      (inValid),
      .aluResult    (aluResult),
      .writeData    (writeData),
      .muxInst      (muxInst),
      .WB           (WB),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memSize      (memSize),
      .memUnsigned  (memUnsigned),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .readDataOut  (readDataOut),
      .aluResultOut (aluResultOut),
      .muxInstOut   (muxInstOut),
      .WBOut        (WBOut),
      .outValid     (outValid),
      .misalign     (misalign),
      .busErr       (busErr)
   );

   // 10 ns clock; inputs are driven and outputs sampled on the falling edge
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Every comparison funnels through here so the counters stay honest
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one EX_MEM bundle onto the inputs
   task automatic applyStimulus(input logic valid, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] inst,
                                input logic [1:0] wb, input logic rd,
                                input logic wr, input logic [1:0] size,
                                input logic uns);
      inValid     = valid;
      aluResult   = alu;
      writeData   = wd;
      muxInst     = inst;
      WB          = wb;
      memRead     = rd;
      memWrite    = wr;
      memSize     = size;
      memUnsigned = uns;
   endtask

   // Walk through a BUSY period: withhold ack for noAck stall cycles, then
   // ack with rdata. Returns on the first falling edge where stall is low,
   // with the request fields seen on the ack cycle. Bounded so a stuck DUT
   // still reaches the summary.
   task automatic runBusy(input int noAck, input logic [31:0] rdata);
      bit done;
      stallCycles = 0;
      reqCycles   = 0;
      done        = 0;
      ackAddr     = '0;
      ackBe       = '0;
      ackWdata    = '0;
      ackWe       = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clock);
         if (!stall) begin
            done     = 1;
            dmem_ack = 1'b0;
         end else begin
            stallCycles++;
            if (dmem_req) reqCycles++;
            if (stallCycles == noAck + 1) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
               ackAddr    = dmem_addr;
               ackBe      = dmem_be;
               ackWdata   = dmem_wdata;
               ackWe      = dmem_we;
            end else begin
               dmem_ack = 1'b0;
            end
         end
      end
      if (!done) checkOutput("busyBound", 32'(stallCycles), 32'd0);
   endtask

   // Hard stop in case something above blocks unexpectedly
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario sequence
   initial begin
      numCompared   = 0;
      numMismatched = 0;
      reset_n       = 1'b0;
      dmem_ack      = 1'b0;
      dmem_rdata    = '0;
      applyStimulus(0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 0);

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("rstOutValid", 32'(outValid), 32'd0);
      checkOutput("rstStall",    32'(stall),    32'd0);
      checkOutput("rstReq",      32'(dmem_req), 32'd0);
      checkOutput("rstWBOut",    32'(WBOut),    32'd0);
      checkOutput("rstReadData", readDataOut,   32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      // ALU op passes straight through with one cycle of latency
      applyStimulus(1, 32'h10, 32'h0, 5'd5, 2'b10, 0, 0, 2'b10, 0);
      checkOutput("aluStallPre", 32'(stall), 32'd0);
      @(negedge clock);
      checkOutput("aluOutValid", 32'(outValid),   32'd1);
      checkOutput("aluResult",   aluResultOut,    32'h10);
      checkOutput("aluInst",     32'(muxInstOut), 32'd5);
      checkOutput("aluWB",       32'(WBOut),      32'd2);
      checkOutput("aluReadData", readDataOut,     32'h0);
      checkOutput("aluStall",    32'(stall),      32'd0);
      checkOutput("aluReq",      32'(dmem_req),   32'd0);

      // Bubble
      applyStimulus(0, 32'h0, 32'h0, 5'd0, 2'b10, 0, 0, 2'b00, 0);
      @(negedge clock);
      checkOutput("bubbleValid", 32'(outValid), 32'd0);
      checkOutput("bubbleWB",    32'(WBOut),    32'd0);

      // lb 0x103, ack after 3 wait cycles: lane 3 = 0x80, sign-extended
      applyStimulus(1, 32'h103, 32'h0, 5'd8, 2'b11, 1, 0, 2'b00, 0);
      runBusy(3, 32'h80AABBCC);
      checkOutput("lbStallCycles", 32'(stallCycles), 32'd4);
      checkOutput("lbReqCycles",   32'(reqCycles),   32'd4);
      checkOutput("lbAddr",        ackAddr,          32'h100);
      checkOutput("lbBe",          32'(ackBe),       32'h8);
      checkOutput("lbWe",          32'(ackWe),       32'd0);
      checkOutput("lbOutValid",    32'(outValid),    32'd1);
      checkOutput("lbData",        readDataOut,      32'hFFFFFF80);
      checkOutput("lbWB",          32'(WBOut),       32'd3);
      checkOutput("lbInst",        32'(muxInstOut),  32'd8);
      checkOutput("lbReqDrop",     32'(dmem_req),    32'd0);

      // lbu of the same byte, immediate ack
      applyStimulus(1, 32'h103, 32'h0, 5'd9, 2'b11, 1, 0, 2'b00, 1);
      runBusy(0, 32'h80AABBCC);
      checkOutput("lbuStallCycles", 32'(stallCycles), 32'd1);
      checkOutput("lbuData",        readDataOut,      32'h00000080);

      // lh 0x102: upper half 0x80AA, sign-extended
      applyStimulus(1, 32'h102, 32'h0, 5'd10, 2'b11, 1, 0, 2'b01, 0);
      runBusy(1, 32'h80AABBCC);
      checkOutput("lhData", readDataOut, 32'hFFFF80AA);

      // lhu 0x100: lower half 0xBBCC, zero-extended
      applyStimulus(1, 32'h100, 32'h0, 5'd11, 2'b11, 1, 0, 2'b01, 1);
      runBusy(0, 32'h80AABBCC);
      checkOutput("lhuData", readDataOut, 32'h0000BBCC);

      // lw 0x104 with memRead and memWrite both set behaves as a load
      applyStimulus(1, 32'h104, 32'hDEADBEEF, 5'd12, 2'b11, 1, 1, 2'b10, 0);
      runBusy(0, 32'h12345678);
      checkOutput("lwWe",   32'(ackWe),  32'd0);
      checkOutput("lwBe",   32'(ackBe),  32'hF);
      checkOutput("lwData", readDataOut, 32'h12345678);

      // sh 0x202: upper half lanes, replicated data, held through ack
      applyStimulus(1, 32'h202, 32'h1234ABCD, 5'd0, 2'b00, 0, 1, 2'b01, 0);
      runBusy(1, 32'hFFFFFFFF);
      checkOutput("shBe",       32'(ackBe),       32'hC);
      checkOutput("shWdata",    ackWdata,         32'hABCDABCD);
      checkOutput("shWe",       32'(ackWe),       32'd1);
      checkOutput("shAddr",     ackAddr,          32'h200);
      checkOutput("shReqCycles", 32'(reqCycles),  32'd2);
      checkOutput("shOutValid", 32'(outValid),    32'd1);
      checkOutput("shReadData", readDataOut,      32'h0);

      // sb 0x201: lane 1, byte replicated
      applyStimulus(1, 32'h201, 32'h000000EF, 5'd0, 2'b00, 0, 1, 2'b00, 0);
      runBusy(0, 32'h0);
      checkOutput("sbBe",    32'(ackBe), 32'h2);
      checkOutput("sbWdata", ackWdata,   32'hEFEFEFEF);

      // lw 0x301 is misaligned: dropped without a request
      applyStimulus(1, 32'h301, 32'h0, 5'd4, 2'b11, 1, 0, 2'b10, 0);
      @(negedge clock);
      checkOutput("misReq",      32'(dmem_req), 32'd0);
      checkOutput("misStall",    32'(stall),    32'd0);
      checkOutput("misPulse",    32'(misalign), 32'd1);
      checkOutput("misWB",       32'(WBOut),    32'd0);
      checkOutput("misOutValid", 32'(outValid), 32'd1);
      applyStimulus(0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 0);
      @(negedge clock);
      checkOutput("misPulseEnd", 32'(misalign), 32'd0);

      // lw 0x400 never acked: abort after 16 busy cycles
      applyStimulus(1, 32'h400, 32'h0, 5'd6, 2'b11, 1, 0, 2'b10, 0);
      runBusy(100, 32'h0);
      checkOutput("tmoStallCycles", 32'(stallCycles), 32'd16);
      checkOutput("tmoReqCycles",   32'(reqCycles),   32'd16);
      checkOutput("tmoBusErr",      32'(busErr),      32'd1);
      checkOutput("tmoOutValid",    32'(outValid),    32'd1);
      checkOutput("tmoWB",          32'(WBOut),       32'd0);
      checkOutput("tmoReqDrop",     32'(dmem_req),    32'd0);

      // Late ack while idle must be ignored
      applyStimulus(0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      @(negedge clock);
      dmem_ack = 1'b0;
      checkOutput("lateValid",  32'(outValid), 32'd0);
      checkOutput("lateBusErr", 32'(busErr),   32'd0);
      checkOutput("lateStall",  32'(stall),    32'd0);
      checkOutput("lateReq",    32'(dmem_req), 32'd0);

      // Next instruction after the timeout is processed normally
      applyStimulus(1, 32'h55, 32'h0, 5'd9, 2'b10, 0, 0, 2'b10, 0);
      @(negedge clock);
      checkOutput("postValid",  32'(outValid),   32'd1);
      checkOutput("postResult", aluResultOut,    32'h55);
      checkOutput("postWB",     32'(WBOut),      32'd2);

      // Reset in the middle of an access clears everything immediately
      applyStimulus(1, 32'h500, 32'h0, 5'd7, 2'b11, 1, 0, 2'b10, 0);
      @(negedge clock);
      checkOutput("rbReqBefore", 32'(dmem_req), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rbReq",      32'(dmem_req), 32'd0);
      checkOutput("rbStall",    32'(stall),    32'd0);
      checkOutput("rbOutValid", 32'(outValid), 32'd0);
      checkOutput("rbBusErr",   32'(busErr),   32'd0);
      applyStimulus(0, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 2'b00, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("rbAfterStall", 32'(stall), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
